// File: rtl/apb_aes_host_master.sv
// rtl/apb_aes_host_master.sv - APB3 initiator driven by a valid/ready request/response port
module apb_aes_host_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_tmo_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // A disabled timeout still needs a legal one-bit timer.
    localparam int TMAX_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TMAX_I - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TMAX_I);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            timer       <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        PADDR       <= req_addr_i;
                        PWDATA      <= req_wdata_i;
                        PWRITE      <= req_write_i;
                        PSEL        <= 1'b1;
                        PENABLE     <= 1'b0;
                        req_ready_o <= 1'b0;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    timer   <= '0;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_rdata_o <= PWRITE ? 32'h0 : PRDATA;
                        rsp_err_o   <= PSLVERR;
                        rsp_tmo_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end else if (TIMEOUT_CYCLES != 0 && timer == TLAST) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_rdata_o <= 32'h0;
                        rsp_err_o   <= 1'b1;
                        rsp_tmo_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end else if (timer != TMAX) begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_aes_host_master.sv
// tb/tb_apb_aes_host_master.sv - directed self-checking bench for apb_aes_host_master
module tb_apb_aes_host_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_tmo;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    apb_aes_host_master #(
        .APB_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_write_i(req_write),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .rsp_tmo_o  (rsp_tmo),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    // Issue one request and walk it through SETUP and ACCESS; leaves the DUT in RESP.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic err, input logic tmo);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h5A5A_A5A5;
        check("idle_req_ready", req_ready, 1'b1);
        tick;
        req_valid = 1'b0;
        check("setup_sel_en", {PSEL, PENABLE}, 2'b10);
        check("setup_paddr", PADDR, addr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pwdata", PWDATA, wd);
        check("setup_req_ready", req_ready, 1'b0);
        tick;
        for (int i = 0; i < waits; i++) begin
            check("wait_sel_en", {PSEL, PENABLE}, 2'b11);
            check("wait_paddr", PADDR, addr);
            check("wait_pwdata", PWDATA, wd);
            check("wait_rsp_valid", rsp_valid, 1'b0);
            tick;
        end
        if (!tmo) begin
            PREADY  = 1'b1;
            PRDATA  = rd;
            PSLVERR = err;
            check("last_sel_en", {PSEL, PENABLE}, 2'b11);
            check("last_paddr", PADDR, addr);
            tick;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 32'hFFFF_0000;
        end
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] rd, input logic err, input logic tmo);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        check({tag, "_sel_en"}, {PSEL, PENABLE}, 2'b00);
        check({tag, "_req_ready"}, req_ready, 1'b0);
        check({tag, "_rdata"}, rsp_rdata, rd);
        check({tag, "_err"}, rsp_err, err);
        check({tag, "_tmo"}, rsp_tmo, tmo);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check({tag, "_rel_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rel_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        tick;
        tick;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_sel_en", {PSEL, PENABLE}, 2'b00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr", PADDR, 12'h000);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_err_tmo", {rsp_err, rsp_tmo}, 2'b00);
        HRESET = 1'b0;
        tick;

        // Zero-wait write: SETUP, one ACCESS, then response
        xfer(1'b1, 12'h010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1'b0);
        check_rsp("wr0", 32'h0, 1'b0, 1'b0);
        check("wr0_paddr_hold", PADDR, 12'h010);
        release_rsp("wr0");

        // Read with three wait states
        xfer(1'b0, 12'h123, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0);
        check_rsp("rd3", 32'h1234_5678, 1'b0, 1'b0);
        release_rsp("rd3");

        // Slave error on a read
        xfer(1'b0, 12'h044, 32'h0, 0, 32'hCAFE_0001, 1'b1, 1'b0);
        check_rsp("slverr", 32'hCAFE_0001, 1'b1, 1'b0);
        release_rsp("slverr");

        // Timeout: four ACCESS cycles without PREADY
        xfer(1'b0, 12'h0F0, 32'h0, 4, 32'h0, 1'b0, 1'b1);
        check_rsp("tmo", 32'h0, 1'b1, 1'b1);
        release_rsp("tmo");

        // PREADY exactly on the fourth ACCESS cycle completes normally
        xfer(1'b1, 12'h0F4, 32'h0102_0304, 3, 32'h0, 1'b0, 1'b0);
        check_rsp("edge", 32'h0, 1'b0, 1'b0);
        release_rsp("edge");

        // Back-pressure with a pending request held by the requester
        xfer(1'b0, 12'h200, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 12'h204;
        req_wdata = 32'h7777_8888;
        for (int i = 0; i < 5; i++) begin
            PRDATA = 32'h1111_1111 * (i + 1);
            check_rsp("bp", 32'h0BAD_F00D, 1'b0, 1'b0);
            check("bp_paddr_hold", PADDR, 12'h200);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("bp_rel_rsp_valid", rsp_valid, 1'b0);
        check("bp_rel_req_ready", req_ready, 1'b1);
        check("bp_rel_sel", PSEL, 1'b0);
        tick;
        req_valid = 1'b0;
        PREADY    = 1'b1;
        check("bp_next_sel_en", {PSEL, PENABLE}, 2'b10);
        check("bp_next_paddr", PADDR, 12'h204);
        check("bp_next_pwdata", PWDATA, 32'h7777_8888);
        tick;
        check("bp_next_access", {PSEL, PENABLE}, 2'b11);
        tick;
        PREADY = 1'b0;
        check_rsp("bp_next", 32'h0, 1'b0, 1'b0);
        release_rsp("bp_next");

        // Reset while in ACCESS
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 12'h300;
        req_wdata = 32'hAAAA_5555;
        PREADY    = 1'b0;
        tick;
        req_valid = 1'b0;
        tick;
        check("rstmid_access", {PSEL, PENABLE}, 2'b11);
        HRESET = 1'b1;
        tick;
        HRESET = 1'b0;
        check("rstmid_sel_en", {PSEL, PENABLE}, 2'b00);
        check("rstmid_req_ready", req_ready, 1'b1);
        check("rstmid_rsp_valid", rsp_valid, 1'b0);
        tick;
        check("rstmid_no_rsp", rsp_valid, 1'b0);
        xfer(1'b1, 12'h308, 32'h1357_9BDF, 1, 32'h0, 1'b0, 1'b0);
        check_rsp("after_rst", 32'h0, 1'b0, 1'b0);
        release_rsp("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
